// File: rtl/muon_buf_reader_if.sv
// Signal bundle between the muon buffer read engine and its surroundings:
// writer status flags, memory port B and the outgoing AXI-Stream.
interface muon_buf_reader_if #(
  parameter int NBUF          = 4,
  parameter int BUF_NUM_WIDTH = 2,
  parameter int ADDR_WIDTH    = 14,
  parameter int WC_WIDTH      = 10
);
  logic                     ENABLE;
  logic [NBUF-1:0]          MUON_BUF_FULL;
  logic [BUF_NUM_WIDTH-1:0] MUON_BUF_RNUM;
  logic [WC_WIDTH-1:0]      MUON_BUF_WC;
  logic                     MEM_EN;
  logic [ADDR_WIDTH-1:0]    MEM_ADDR;
  logic [31:0]              MEM_DATA0;
  logic [31:0]              MEM_DATA1;
  logic [31:0]              M_TDATA;
  logic                     M_TVALID;
  logic                     M_TREADY;
  logic                     M_TLAST;
  logic                     BUF_RELEASE;
  logic [BUF_NUM_WIDTH-1:0] BUF_RELEASE_NUM;
  logic                     BUSY;
  logic [15:0]              BUFS_SENT;

  // Reader side: drives memory reads, the stream and the release request.
  modport master (
    input  ENABLE, MUON_BUF_FULL, MUON_BUF_RNUM, MUON_BUF_WC,
    input  MEM_DATA0, MEM_DATA1, M_TREADY,
    output MEM_EN, MEM_ADDR, M_TDATA, M_TVALID, M_TLAST,
    output BUF_RELEASE, BUF_RELEASE_NUM, BUSY, BUFS_SENT
  );

  // Environment side: writer flags, memory data and the stream sink.
  modport slave (
    output ENABLE, MUON_BUF_FULL, MUON_BUF_RNUM, MUON_BUF_WC,
    output MEM_DATA0, MEM_DATA1, M_TREADY,
    input  MEM_EN, MEM_ADDR, M_TDATA, M_TVALID, M_TLAST,
    input  BUF_RELEASE, BUF_RELEASE_NUM, BUSY, BUFS_SENT
  );
endinterface

// File: rtl/muon_buf_reader.sv
// Muon buffer read engine: when the buffer at the writer's read pointer is
// full, reads it pair by pair from memory port B through a small prefetch
// FIFO, streams it as 32-bit AXI-Stream words (bank 0 then bank 1 of each
// pair) and then requests release of the buffer.
module muon_buf_reader #(
  parameter int NBUF          = 4,
  parameter int BUF_NUM_WIDTH = 2,
  parameter int ADDR_WIDTH    = 14,
  parameter int MEM_BUF_SHIFT = 12,
  parameter int WC_WIDTH      = 10,
  parameter int RD_LATENCY    = 2,
  parameter int FIFO_DEPTH    = 4
) (
  input logic AXI_CLK,
  input logic RESETN,
  muon_buf_reader_if.master bus
);
  localparam int IDX_W    = MEM_BUF_SHIFT - 2;
  localparam int NP_W     = IDX_W + 1;
  localparam int PAIR_MAX = 1 << IDX_W;
  localparam int CMP_W    = (WC_WIDTH > NP_W) ? WC_WIDTH : NP_W;
  localparam int FA_W     = $clog2(FIFO_DEPTH);
  localparam int CNT_W    = FA_W + 1;
  localparam int OCC_W    = FA_W + 2;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LATCH    = 3'd1,
    ST_STREAM   = 3'd2,
    ST_RELEASE  = 3'd3,
    ST_WAIT_ACK = 3'd4
  } state_t;

  // A buffer never holds more pairs than its address range allows.
  function automatic logic [NP_W-1:0] clamp_pairs(input logic [WC_WIDTH-1:0] wc);
    logic [CMP_W-1:0] wide;
    wide = CMP_W'(wc);
    if (wide > CMP_W'(PAIR_MAX)) clamp_pairs = NP_W'(PAIR_MAX);
    else                         clamp_pairs = NP_W'(wide);
  endfunction

  state_t                   state_r;
  logic [BUF_NUM_WIDTH-1:0] bufnum_r;
  logic [NP_W-1:0]          npairs_r;
  logic [NP_W-1:0]          rd_cnt_r;
  logic [NP_W-1:0]          out_cnt_r;
  logic                     half_r;
  logic                     mem_en_r;
  logic [ADDR_WIDTH-1:0]    mem_addr_r;
  logic [RD_LATENCY-1:0]    vld_r;
  logic [63:0]              fifo_mem [FIFO_DEPTH];
  logic [FA_W-1:0]          wr_ptr_r;
  logic [FA_W-1:0]          rd_ptr_r;
  logic [CNT_W-1:0]         fifo_cnt_r;
  logic [CNT_W-1:0]         outstanding_r;
  logic                     tvalid_r;
  logic                     tlast_r;
  logic [31:0]              tdata_r;
  logic                     release_r;
  logic [BUF_NUM_WIDTH-1:0] release_num_r;
  logic                     busy_r;
  logic [15:0]              bufs_sent_r;

  logic [NBUF-1:0]  full_s;
  logic [NP_W-1:0]  npairs_s;
  logic [OCC_W-1:0] occ_s;
  logic [63:0]      head_s;
  logic             issue_s;
  logic             push_s;
  logic             load_s;
  logic             pop_s;

  // Read issue, FIFO push/pop and output-stage load decisions.
  always_comb begin
    full_s   = bus.MUON_BUF_FULL;
    npairs_s = clamp_pairs(bus.MUON_BUF_WC);
    occ_s    = OCC_W'(fifo_cnt_r) + OCC_W'(outstanding_r);
    head_s   = fifo_mem[rd_ptr_r];
    issue_s  = 1'b0;
    load_s   = 1'b0;
    push_s   = vld_r[RD_LATENCY-1];
    if (state_r == ST_STREAM) begin
      // Reads in flight already own a FIFO slot, so the FIFO can never overflow.
      issue_s = (rd_cnt_r < npairs_r) && (occ_s < OCC_W'(FIFO_DEPTH));
      load_s  = (!tvalid_r || bus.M_TREADY) && (fifo_cnt_r != CNT_W'(0));
    end else begin
      issue_s = 1'b0;
      load_s  = 1'b0;
    end
    pop_s = load_s && half_r;
  end

  // Memory read issue, read-latency tracking and FIFO bookkeeping.
  always_ff @(posedge AXI_CLK) begin
    if (!RESETN) begin
      mem_en_r      <= 1'b0;
      mem_addr_r    <= {ADDR_WIDTH{1'b0}};
      vld_r         <= {RD_LATENCY{1'b0}};
      rd_cnt_r      <= {NP_W{1'b0}};
      wr_ptr_r      <= {FA_W{1'b0}};
      rd_ptr_r      <= {FA_W{1'b0}};
      fifo_cnt_r    <= {CNT_W{1'b0}};
      outstanding_r <= {CNT_W{1'b0}};
    end else begin
      mem_en_r <= issue_s;
      if (issue_s) begin
        mem_addr_r <= ADDR_WIDTH'({bufnum_r, rd_cnt_r[IDX_W-1:0], 2'b00});
        rd_cnt_r   <= rd_cnt_r + NP_W'(1);
      end else if (state_r == ST_LATCH) begin
        rd_cnt_r <= {NP_W{1'b0}};
      end
      vld_r[0] <= mem_en_r;
      for (int k = 1; k < RD_LATENCY; k++) vld_r[k] <= vld_r[k-1];
      if (push_s) wr_ptr_r <= wr_ptr_r + FA_W'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + FA_W'(1);
      fifo_cnt_r    <= fifo_cnt_r + CNT_W'(push_s) - CNT_W'(pop_s);
      outstanding_r <= outstanding_r + CNT_W'(issue_s) - CNT_W'(push_s);
    end
  end

  // Prefetch FIFO storage; occupancy is governed by the pointers above.
  always_ff @(posedge AXI_CLK) begin
    if (push_s) fifo_mem[wr_ptr_r] <= {bus.MEM_DATA1, bus.MEM_DATA0};
  end

  // Buffer-level FSM with the registered stream and release outputs.
  always_ff @(posedge AXI_CLK) begin
    if (!RESETN) begin
      state_r       <= ST_IDLE;
      bufnum_r      <= {BUF_NUM_WIDTH{1'b0}};
      npairs_r      <= {NP_W{1'b0}};
      out_cnt_r     <= {NP_W{1'b0}};
      half_r        <= 1'b0;
      tvalid_r      <= 1'b0;
      tlast_r       <= 1'b0;
      tdata_r       <= 32'd0;
      release_r     <= 1'b0;
      release_num_r <= {BUF_NUM_WIDTH{1'b0}};
      busy_r        <= 1'b0;
      bufs_sent_r   <= 16'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          release_r <= 1'b0;
          if (bus.ENABLE && full_s[bus.MUON_BUF_RNUM]) begin
            state_r <= ST_LATCH;
            busy_r  <= 1'b1;
          end
        end
        ST_LATCH: begin
          bufnum_r  <= bus.MUON_BUF_RNUM;
          npairs_r  <= npairs_s;
          out_cnt_r <= {NP_W{1'b0}};
          half_r    <= 1'b0;
          if (npairs_s == NP_W'(0)) begin
            state_r       <= ST_RELEASE;
            release_r     <= 1'b1;
            release_num_r <= bus.MUON_BUF_RNUM;
            bufs_sent_r   <= bufs_sent_r + 16'd1;
          end else begin
            state_r <= ST_STREAM;
          end
        end
        ST_STREAM: begin
          if (load_s) begin
            tvalid_r <= 1'b1;
            tdata_r  <= half_r ? head_s[63:32] : head_s[31:0];
            tlast_r  <= half_r && (out_cnt_r == npairs_r - NP_W'(1));
            half_r   <= ~half_r;
            if (half_r) out_cnt_r <= out_cnt_r + NP_W'(1);
          end else if (tvalid_r && bus.M_TREADY) begin
            tvalid_r <= 1'b0;
            tlast_r  <= 1'b0;
            if (tlast_r) begin
              state_r       <= ST_RELEASE;
              release_r     <= 1'b1;
              release_num_r <= bufnum_r;
              bufs_sent_r   <= bufs_sent_r + 16'd1;
            end
          end
        end
        ST_RELEASE: begin
          release_r <= 1'b0;
          state_r   <= ST_WAIT_ACK;
        end
        ST_WAIT_ACK: begin
          // Leave only once the writer has seen the release, or this buffer would be resent.
          if (!full_s[bufnum_r] || (bus.MUON_BUF_RNUM != bufnum_r)) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          busy_r    <= 1'b0;
          release_r <= 1'b0;
          tvalid_r  <= 1'b0;
          tlast_r   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.MEM_EN          = mem_en_r;
  assign bus.MEM_ADDR        = mem_addr_r;
  assign bus.M_TDATA         = tdata_r;
  assign bus.M_TVALID        = tvalid_r;
  assign bus.M_TLAST         = tlast_r;
  assign bus.BUF_RELEASE     = release_r;
  assign bus.BUF_RELEASE_NUM = release_num_r;
  assign bus.BUSY            = busy_r;
  assign bus.BUFS_SENT       = bufs_sent_r;
endmodule
